// File: rtl/bg_pkg.sv
// Shared types, palette and cell hash for the parallax starfield generator.
package bg_pkg;

  typedef logic [5:0] rgb222_t;

  localparam logic [15:0] HASH_MX = 16'h9E37;
  localparam logic [15:0] HASH_MY = 16'h85EB;
  localparam logic [15:0] HASH_ML = 16'h2F1D;

  // white 333, yellow 331, blue 123, red 310
  localparam rgb222_t PALETTE [0:3] = '{6'b11_11_11, 6'b11_11_01, 6'b01_10_11, 6'b11_01_00};

  function automatic logic [15:0] star_hash(input logic [10:0] cx, input logic [10:0] cy,
                                            input logic [1:0] layer);
    logic [15:0] h0;
    h0 = (16'(cx) * HASH_MX) ^ (16'(cy) * HASH_MY) ^ (16'(layer) * HASH_ML);
    return h0 ^ (h0 >> 7);
  endfunction

  function automatic rgb222_t dim(input rgb222_t c);
    return {1'b0, c[5], 1'b0, c[3], 1'b0, c[1]};
  endfunction

endpackage

// File: rtl/bg_star_layer.sv
// One parallax layer: scroll offset, cell/local coordinate stage and the
// combinational star test on the registered cell coordinates.
module bg_star_layer
  import bg_pkg::*;
#(
  parameter int         LAYER      = 0,
  parameter bit         NEAREST    = 1'b0,
  parameter int         CELL_LOG2  = 4,
  parameter logic [3:0] DENSITY    = 4'd5,
  parameter int         SPEED_BASE = 1,
  parameter bit         TWINKLE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        bg_en,
  input  logic        scroll_dir,
  input  logic        video_active,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic [2:0]  phase,
  output logic        star,
  output rgb222_t     colour
);

  localparam int          CW   = 11 - CELL_LOG2;
  localparam logic [10:0] STEP = 11'((LAYER + 1) * SPEED_BASE);

  logic [10:0]          off;
  logic [10:0]          sx;
  logic [CW-1:0]        cx_q, cy_q;
  logic [CELL_LOG2-1:0] lx_q, ly_q;
  logic                 valid_q;
  logic [15:0]          h;
  rgb222_t              base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off <= '0;
    end else if (tick && bg_en) begin
      off <= scroll_dir ? off - STEP : off + STEP;
    end
  end

  assign sx = pix_x + off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q    <= '0;
      cy_q    <= '0;
      lx_q    <= '0;
      ly_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      cx_q    <= sx[10:CELL_LOG2];
      cy_q    <= pix_y[10:CELL_LOG2];
      lx_q    <= sx[CELL_LOG2-1:0];
      ly_q    <= pix_y[CELL_LOG2-1:0];
      valid_q <= video_active && bg_en;
    end
  end

  // Phase is the live register, so a tick at the stage-1 edge already counts.
  always_comb begin
    h      = star_hash(11'(cx_q), 11'(cy_q), 2'(LAYER));
    star   = valid_q && (h[15:12] < DENSITY) && (lx_q == h[CELL_LOG2-1:0]) &&
             (ly_q == h[CELL_LOG2+3:4]) && !(TWINKLE && (h[11:9] == phase));
    base   = PALETTE[h[9:8]];
    colour = NEAREST ? base : dim(base);
  end

endmodule

// File: rtl/bg_starfield_parallax.sv
// Multi-layer hashed starfield: frame tick, twinkle phase, layer priority merge
// and registered RGB222 output, two clocks after the pixel coordinates.
module bg_starfield_parallax
  import bg_pkg::*;
#(
  parameter int         NUM_LAYERS = 3,
  parameter int         CELL_LOG2  = 4,
  parameter logic [3:0] DENSITY    = 4'd5,
  parameter int         SPEED_BASE = 1,
  parameter bit         VSYNC_POL  = 1'b1,
  parameter bit         TWINKLE    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bg_en,
  input  logic        scroll_dir,
  input  logic        video_active,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        vsync,
  output logic [1:0]  R,
  output logic [1:0]  G,
  output logic [1:0]  B
);

  logic                  vsync_d;
  logic                  tick;
  logic [2:0]            phase;
  logic [NUM_LAYERS-1:0] star;
  rgb222_t               colour [NUM_LAYERS];
  rgb222_t               pix_c;

  assign tick = (vsync == VSYNC_POL) && (vsync_d != VSYNC_POL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= !VSYNC_POL;
      phase   <= '0;
    end else begin
      vsync_d <= vsync;
      if (tick && bg_en) phase <= phase + 3'd1;
    end
  end

  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
    bg_star_layer #(
      .LAYER      (l),
      .NEAREST    (l == NUM_LAYERS - 1),
      .CELL_LOG2  (CELL_LOG2),
      .DENSITY    (DENSITY),
      .SPEED_BASE (SPEED_BASE),
      .TWINKLE    (TWINKLE)
    ) u_layer (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick         (tick),
      .bg_en        (bg_en),
      .scroll_dir   (scroll_dir),
      .video_active (video_active),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .phase        (phase),
      .star         (star[l]),
      .colour       (colour[l])
    );
  end

  // Later (nearer) layers overwrite earlier ones.
  always_comb begin
    pix_c = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (star[l]) pix_c = colour[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {R, G, B} <= '0;
    end else begin
      {R, G, B} <= pix_c;
    end
  end

endmodule

// File: tb/tb_bg_starfield_parallax.sv
// Randomized bench for bg_starfield_parallax against an arithmetic starfield model.
module tb_bg_starfield_parallax;

  localparam int NL  = 3;
  localparam int CL  = 4;
  localparam int DEN = 5;
  localparam int SPD = 1;
  localparam int TW  = 1;
  localparam int CELL = 1 << CL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bg_en = 1'b0;
  logic        scroll_dir = 1'b0;
  logic        video_active = 1'b0;
  logic [10:0] pix_x = '0;
  logic [10:0] pix_y = '0;
  logic        vsync = 1'b0;
  logic [1:0]  R, G, B;

  int n_cmp = 0;
  int n_fail = 0;

  int          m_off [NL];
  int          m_phase;
  logic        m_vsd;
  logic [5:0]  pend;

  bg_starfield_parallax #(
    .NUM_LAYERS(NL), .CELL_LOG2(CL), .DENSITY(4'(DEN)), .SPEED_BASE(SPD),
    .VSYNC_POL(1'b1), .TWINKLE(1'(TW))
  ) dut (
    .clk(clk), .rst_n(rst_n), .bg_en(bg_en), .scroll_dir(scroll_dir),
    .video_active(video_active), .pix_x(pix_x), .pix_y(pix_y), .vsync(vsync),
    .R(R), .G(G), .B(B)
  );

  always #5 clk = ~clk;

  function automatic int hsh(input int cx, input int cy, input int l);
    int h0;
    h0 = ((cx * 'h9E37) ^ (cy * 'h85EB) ^ (l * 'h2F1D)) & 'hFFFF;
    return h0 ^ (h0 >> 7);
  endfunction

  function automatic logic [5:0] rgb(input int idx, input bit dimmed);
    int r, g, b;
    case (idx)
      0:       begin r = 3; g = 3; b = 3; end
      1:       begin r = 3; g = 3; b = 1; end
      2:       begin r = 1; g = 2; b = 3; end
      default: begin r = 3; g = 1; b = 0; end
    endcase
    if (dimmed) begin r = r / 2; g = g / 2; b = b / 2; end
    return {2'(r), 2'(g), 2'(b)};
  endfunction

  function automatic bit is_star(input int l, input int x, input int y, input int ph);
    int sx, h;
    sx = (x + m_off[l]) % 2048;
    h  = hsh(sx / CELL, y / CELL, l);
    return ((h >> 12) < DEN) && ((sx % CELL) == (h % CELL)) &&
           ((y % CELL) == ((h >> 4) % CELL)) && !(TW != 0 && ((h >> 9) & 7) == ph);
  endfunction

  function automatic logic [5:0] model_pix(input int x, input int y, input int ph);
    logic [5:0] r;
    int sx;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      if (is_star(l, x, y, ph)) begin
        sx = (x + m_off[l]) % 2048;
        r  = rgb((hsh(sx / CELL, y / CELL, l) >> 8) & 3, l < NL - 1);
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) m_off[l] = 0;
    m_phase = 0;
    m_vsd   = 1'b0;
    pend    = '0;
  endtask

  task automatic check(input string tag, input logic [5:0] exp);
    n_cmp++;
    assert ({R, G, B} === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, {R, G, B}, exp);
    end
  endtask

  // One pixel clock with the inputs as currently driven.
  task automatic cyc(input string tag);
    bit         tk;
    int         nph;
    logic [5:0] e;
    tk  = (vsync == 1'b1) && (m_vsd == 1'b0);
    nph = (tk && bg_en) ? (m_phase + 1) % 8 : m_phase;
    e   = (video_active && bg_en) ? model_pix(int'(pix_x), int'(pix_y), nph) : 6'd0;
    if (tk && bg_en) begin
      for (int l = 0; l < NL; l++)
        m_off[l] = scroll_dir ? (m_off[l] - (l + 1) * SPD + 2048) % 2048
                              : (m_off[l] + (l + 1) * SPD) % 2048;
      m_phase = nph;
    end
    m_vsd = vsync;
    @(posedge clk);
    #1;
    check(tag, pend);
    pend = e;
  endtask

  // Point at a pixel where some layer would place its star in a random cell.
  task automatic pick_target();
    int l, cx, cy, h, sx;
    l  = $urandom_range(0, NL - 1);
    cx = $urandom_range(0, 2048 / CELL - 1);
    cy = $urandom_range(0, 2048 / CELL - 1);
    h  = hsh(cx, cy, l);
    sx = cx * CELL + (h % CELL);
    pix_y = 11'(cy * CELL + ((h >> 4) % CELL));
    pix_x = 11'((sx - m_off[l] + 2048) % 2048);
  endtask

  task automatic pick_pixel();
    if ($urandom_range(0, 1) == 0) pick_target();
    else begin
      pix_x = 11'($urandom_range(0, 2047));
      pix_y = 11'($urandom_range(0, 2047));
    end
  endtask

  int ovx [$];
  int ovy [$];

  initial begin
    model_reset();
    #7;
    check("reset_out", 6'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle at (0,0): black until video_active rises, then cell (0,0).
    bg_en = 1'b1;
    repeat (3) cyc("idle_black");
    video_active = 1'b1;
    repeat (4) cyc("cell00");

    // Random frames with random scroll direction and enable.
    for (int i = 0; i < 600; i++) begin
      vsync        = ($urandom_range(0, 3) == 0);
      bg_en        = ($urandom_range(0, 7) != 0);
      scroll_dir   = ($urandom_range(0, 15) == 0) ? ~scroll_dir : scroll_dir;
      video_active = ($urandom_range(0, 7) != 0);
      pick_pixel();
      cyc("random");
    end

    // Disabled for 5 vsync pulses: black and frozen, then resume.
    bg_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vsync = (i % 2 == 0);
      pick_pixel();
      cyc("disabled");
    end
    bg_en = 1'b1;
    vsync = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pick_target();
      cyc("reenabled");
    end

    // Long forward run so every offset wraps past 2047.
    scroll_dir = 1'b0;
    for (int i = 0; i < 4200; i++) begin
      vsync = (i % 2 == 0);
      pick_pixel();
      cyc("wrap");
    end
    vsync = 1'b0;

    // Pixels where two layers both place a star: nearer layer must win.
    for (int a = 0; a < NL - 1; a++)
      for (int b = a + 1; b < NL; b++)
        for (int cy = 0; cy < 2048 / CELL; cy++)
          for (int cx = 0; cx < 2048 / CELL; cx++) begin
            int h, sx, x, y, sxb, hb;
            h = hsh(cx, cy, a);
            if ((h >> 12) < DEN && ovx.size() < 12) begin
              sx  = cx * CELL + (h % CELL);
              y   = cy * CELL + ((h >> 4) % CELL);
              x   = (sx - m_off[a] + 2048) % 2048;
              sxb = (x + m_off[b]) % 2048;
              hb  = hsh(sxb / CELL, cy, b);
              if ((hb >> 12) < DEN && (sxb % CELL) == (hb % CELL) &&
                  (y % CELL) == ((hb >> 4) % CELL)) begin
                ovx.push_back(x);
                ovy.push_back(y);
              end
            end
          end
    for (int k = 0; k < ovx.size(); k++) begin
      pix_x = 11'(ovx[k]);
      pix_y = 11'(ovy[k]);
      cyc("overlap");
    end

    // Reset mid-frame: outputs clear at once, black for 2 clk after release.
    for (int i = 0; i < 20; i++) begin
      pick_target();
      cyc("pre_reset");
    end
    rst_n = 1'b0;
    #1;
    check("async_reset", 6'd0);
    model_reset();
    @(posedge clk); #1;
    check("reset_hold", 6'd0);
    rst_n = 1'b1;

    // Eight frames forward from reset, then targeted pixels.
    for (int i = 0; i < 16; i++) begin
      vsync = (i % 2 == 0);
      pick_pixel();
      cyc("after_reset");
    end
    vsync = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pick_target();
      cyc("frame8");
    end
    cyc("drain");
    cyc("drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_starfield_parallax.md
Name: bg_starfield_parallax

Overview:
Procedural multi-layer parallax starfield generator for the scrolling-background family. Stars come from a per-cell hash, not from fixed coordinate tables, so density and layer count scale by parameter with no extra storage. Each layer scrolls horizontally at its own per-frame speed, and stars twinkle by frame phase. Output is registered RGB222 with a fixed latency. It drops into the background mux alongside the other bg_* generators.

Parameters:
NUM_LAYERS, 3, number of parallax layers (1..4); layer NUM_LAYERS-1 is nearest.
CELL_LOG2, 4, log2 of the square cell size in pixels; at most one star per cell per layer (3..5).
DENSITY, 4'd5, a star exists in a cell when hash[15:12] < DENSITY (0 gives no stars; 15 gives 15/16 of cells).
SPEED_BASE, 1, layer l advances (l+1)*SPEED_BASE pixels per frame.
VSYNC_POL, 1, active level of vsync; a frame tick is the leading edge into the active level.
TWINKLE, 1, 0 disables twinkle blanking.

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
bg_en  in  1  generator enable; low freezes scroll and forces black
scroll_dir  in  1  0 = stars move left (offset added), 1 = move right (offset subtracted)
video_active  in  1  current pixel is valid
pix_x  in  11  pixel column
pix_y  in  11  pixel row
vsync  in  1  vertical sync, same clock domain as clk
R  out  2  red
G  out  2  green
B  out  2  blue

Behaviour:
- Reset is asynchronous active-low. R/G/B = 0; all layer offsets = 0; twinkle phase = 0; vsync_d = inactive level; pipeline valid flags = 0.
- Frame tick: register vsync_d each clk. tick = (vsync==VSYNC_POL) && (vsync_d!=VSYNC_POL). At most one tick per frame.
- On a tick with bg_en=1:
  - off_l[10:0] += (l+1)*SPEED_BASE when scroll_dir=0; subtract when scroll_dir=1. Arithmetic is mod 2048 and wraps silently.
  - phase[2:0] increments by 1.
- With bg_en=0, offsets and phase hold.
- Stage 1 (registered), per layer:
  - sx_l = (pix_x + off_l) mod 2048.
  - cx = sx_l >> CELL_LOG2; cy = pix_y >> CELL_LOG2.
  - lx = sx_l low CELL_LOG2 bits; ly = pix_y low CELL_LOG2 bits.
  - Register cx, cy, lx, ly and video_active && bg_en.
- Stage 2 (registered outputs):
  - h0 = (cx*16'h9E37) ^ (cy*16'h85EB) ^ (l*16'h2F1D), taken mod 2^16; h = h0 ^ (h0 >> 7).
  - star_l = (h[15:12] < DENSITY) && (lx == h[CELL_LOG2-1:0]) && (ly == h[CELL_LOG2+3:4] truncated to CELL_LOG2 bits) && !(TWINKLE && h[11:9]==phase).
  - Colour index = h[9:8] into PALETTE: 0 white 333, 1 yellow 331, 2 blue 123, 3 red 310.
  - Layers l < NUM_LAYERS-1 are dimmed: each channel is shifted right by 1.
  - Priority: the highest-index layer with star_l wins. No star gives 000.
  - If the stage-1 valid flag is 0, the output is 000.
- Latency: exactly 2 clk from pix_x/pix_y/video_active to R/G/B. There is no throughput stall; one pixel per clock.
- A tick arriving mid-line updates offsets immediately. Normal use puts vsync in blanking, so no visible tear is expected.
- A reset asserted mid-frame clears outputs in the same instant. After release, output is black for 2 clk, then valid.
- Toggling bg_en mid-frame takes effect on the pixel entering stage 1 two cycles earlier; no state is lost.

Decomposition:
- Package bg_pkg:
  - PALETTE[0:3] RGB222 constants.
  - Hash multipliers 16'h9E37, 16'h85EB, 16'h2F1D.
  - Function star_hash(cx, cy, layer) returning 16 bits.
  - rgb222_t typedef.
- Sub-module bg_star_layer, instantiated NUM_LAYERS times from a generate loop:
  - Holds that layer's offset register.
  - Runs both pipeline stages for that layer.
  - Outputs star_l and a 6-bit colour.
- The top level holds the tick detect, phase counter, priority merge and output registers.

Test Plan:
- Reset then idle, DENSITY=15, TWINKLE=0, pix_x=0 and pix_y=0 held: output stays 000 until 2 clk after the first cycle with video_active=1 and bg_en=1; it then matches the golden hash model for cell (0,0).
- Drive 8 vsync pulses, bg_en=1, scroll_dir=0, NUM_LAYERS=3: off_0=8, off_1=16, off_2=24. A star seen at pix_x=X in frame 0 on layer 2 appears at X-24 in frame 8.
- off_0 preloaded near wrap (2046 after 2046 ticks, SPEED_BASE=1), one more tick: off_0=2047, then 0. The star pattern is continuous across the wrap; no X or glitch.
- bg_en=0 for 5 vsync pulses: offsets and phase unchanged, R/G/B=000 throughout. Re-enable: resumes the identical pattern.
- TWINKLE=1, a star with h[11:9]=3: dark exactly in frames where phase=3 (every 8th), lit otherwise.
- Overlap case with a layer-0 and a layer-2 star on the same pixel: output is the full-brightness layer-2 colour. A layer-0-only white star outputs 111 (dimmed 333).
